eth_hdr_insert: RTL

Transmit-side Ethernet framer, the outbound counterpart of the receive-path header strip and EtherType filter. Accepts an `eth_hdr` plus payload stream on the split header/data interface used by the rest of the network stack. Emits a single MAC-width stream toward the MAC with the 14-byte Ethernet header prepended and all payload bytes realigned behind it.

---
 rtl/eth_hdr_insert_pkg.sv | 28 ++
 rtl/eth_hdr_insert_ctrl.sv | 104 ++++++++++
 rtl/eth_hdr_insert.sv | 75 +++++++
 3 files changed

// File: rtl/eth_hdr_insert_pkg.sv
// Shared widths, the Ethernet header layout and the output-mux select used by
// the transmit framer.
package eth_hdr_insert_pkg;

    localparam int MAC_INTERFACE_W = 512;
    localparam int MAC_PADBYTES_W  = 6;
    localparam int MTU_SIZE_W      = 16;
    localparam int MAC_BYTES       = MAC_INTERFACE_W / 8;

    localparam int ETH_HDR_BYTES = 14;
    localparam int ETH_HDR_W     = ETH_HDR_BYTES * 8;
    localparam int BODY_W        = MAC_INTERFACE_W - ETH_HDR_W;

    typedef struct packed {
        logic [47:0] dst_mac;
        logic [47:0] src_mac;
        logic [15:0] eth_type;
    } eth_hdr;

    typedef enum logic [2:0] {
        SEL_ZERO,
        SEL_HDR_ONLY,
        SEL_HDR_IN,
        SEL_CARRY_IN,
        SEL_CARRY_FLUSH
    } out_sel_e;

endpackage

// File: rtl/eth_hdr_insert_ctrl.sv
// Framing FSM: decides valid/ready/last/padbytes, register loads and the
// output mux select. Payload beats pass through combinationally in FIRST/BODY.
//
// state    | meaning
// IDLE     | waiting for a header
// HDR_ONLY | emitting a header-only frame
// FIRST    | first payload beat, header in front
// BODY     | later payload beats, previous tail in front
// FLUSH    | emitting leftover tail bytes after the final input beat
module eth_hdr_insert_ctrl
    import eth_hdr_insert_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      hdr_val,
    input  logic                      size_zero,
    input  logic                      src_val,
    input  logic                      src_last,
    input  logic [MAC_PADBYTES_W-1:0] src_padbytes,
    input  logic [MAC_PADBYTES_W-1:0] p_reg,
    input  logic                      dst_rdy,
    output logic                      hdr_rdy,
    output logic                      src_rdy,
    output logic                      dst_val,
    output logic                      dst_last,
    output logic [MAC_PADBYTES_W-1:0] dst_padbytes,
    output out_sel_e                  sel,
    output logic                      hdr_load,
    output logic                      carry_load,
    output logic                      p_load
);

    typedef enum logic [2:0] {IDLE, HDR_ONLY, FIRST, BODY, FLUSH} state_e;

    localparam logic [MAC_PADBYTES_W-1:0] HDR_BYTES_P = MAC_PADBYTES_W'(ETH_HDR_BYTES);
    localparam logic [MAC_PADBYTES_W-1:0] TAIL_PAD    = MAC_PADBYTES_W'(MAC_BYTES - ETH_HDR_BYTES);

    state_e state;
    logic   in_payload;
    logic   beat_hs;
    logic   fits_last;

    always_comb begin
        in_payload   = (state == FIRST) || (state == BODY);
        beat_hs      = in_payload && src_val && dst_rdy;
        // Enough padding on the last input beat to absorb the 14-byte shift.
        fits_last    = src_padbytes >= HDR_BYTES_P;
        hdr_rdy      = 1'b0;
        src_rdy      = 1'b0;
        dst_val      = 1'b0;
        dst_last     = 1'b0;
        dst_padbytes = '0;
        sel          = SEL_ZERO;
        case (state)
            IDLE: hdr_rdy = 1'b1;
            HDR_ONLY: begin
                dst_val      = 1'b1;
                dst_last     = 1'b1;
                dst_padbytes = TAIL_PAD;
                sel          = SEL_HDR_ONLY;
            end
            FIRST, BODY: begin
                dst_val = src_val;
                src_rdy = dst_rdy;
                sel     = (state == FIRST) ? SEL_HDR_IN : SEL_CARRY_IN;
                if (src_last && fits_last) begin
                    dst_last     = 1'b1;
                    dst_padbytes = src_padbytes - HDR_BYTES_P;
                end
            end
            FLUSH: begin
                dst_val      = 1'b1;
                dst_last     = 1'b1;
                dst_padbytes = TAIL_PAD + p_reg;
                sel          = SEL_CARRY_FLUSH;
            end
            default: ;
        endcase
        hdr_load   = (state == IDLE) && hdr_val;
        carry_load = beat_hs;
        p_load     = beat_hs && src_last && !fits_last;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:     if (hdr_val) state <= size_zero ? HDR_ONLY : FIRST;
                HDR_ONLY: if (dst_rdy) state <= IDLE;
                FIRST, BODY: begin
                    if (src_val && dst_rdy) begin
                        if (!src_last)     state <= BODY;
                        else if (fits_last) state <= IDLE;
                        else               state <= FLUSH;
                    end
                end
                FLUSH:    if (dst_rdy) state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/eth_hdr_insert.sv
// Transmit framer top: prepends the Ethernet header to the payload stream and
// realigns payload bytes behind it; holds the header, tail carry and pad latch.
module eth_hdr_insert
    import eth_hdr_insert_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  eth_hdr                     src_eth_insert_eth_hdr,
    input  logic [MTU_SIZE_W-1:0]      src_eth_insert_data_size,
    input  logic                       src_eth_insert_hdr_val,
    output logic                       eth_insert_src_hdr_rdy,
    input  logic                       src_eth_insert_data_val,
    input  logic [MAC_INTERFACE_W-1:0] src_eth_insert_data,
    input  logic                       src_eth_insert_data_last,
    input  logic [MAC_PADBYTES_W-1:0]  src_eth_insert_data_padbytes,
    output logic                       eth_insert_src_data_rdy,
    output logic                       eth_insert_dst_data_val,
    output logic [MAC_INTERFACE_W-1:0] eth_insert_dst_data,
    output logic                       eth_insert_dst_data_last,
    output logic [MAC_PADBYTES_W-1:0]  eth_insert_dst_data_padbytes,
    input  logic                       dst_eth_insert_data_rdy
);

    logic [ETH_HDR_W-1:0]      hdr_reg;
    logic [ETH_HDR_W-1:0]      carry_reg;
    logic [MAC_PADBYTES_W-1:0] p_reg;
    out_sel_e                  sel;
    logic                      hdr_load;
    logic                      carry_load;
    logic                      p_load;

    eth_hdr_insert_ctrl u_ctrl (
        .clk          (clk),
        .rst          (rst),
        .hdr_val      (src_eth_insert_hdr_val),
        .size_zero    (src_eth_insert_data_size == '0),
        .src_val      (src_eth_insert_data_val),
        .src_last     (src_eth_insert_data_last),
        .src_padbytes (src_eth_insert_data_padbytes),
        .p_reg        (p_reg),
        .dst_rdy      (dst_eth_insert_data_rdy),
        .hdr_rdy      (eth_insert_src_hdr_rdy),
        .src_rdy      (eth_insert_src_data_rdy),
        .dst_val      (eth_insert_dst_data_val),
        .dst_last     (eth_insert_dst_data_last),
        .dst_padbytes (eth_insert_dst_data_padbytes),
        .sel          (sel),
        .hdr_load     (hdr_load),
        .carry_load   (carry_load),
        .p_load       (p_load)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_reg   <= '0;
            carry_reg <= '0;
            p_reg     <= '0;
        end else begin
            if (hdr_load)   hdr_reg   <= src_eth_insert_eth_hdr;
            if (carry_load) carry_reg <= src_eth_insert_data[ETH_HDR_W-1:0];
            if (p_load)     p_reg     <= src_eth_insert_data_padbytes;
        end
    end

    always_comb begin
        case (sel)
            SEL_HDR_ONLY:    eth_insert_dst_data = {hdr_reg, {BODY_W{1'b0}}};
            SEL_HDR_IN:      eth_insert_dst_data = {hdr_reg, src_eth_insert_data[MAC_INTERFACE_W-1:ETH_HDR_W]};
            SEL_CARRY_IN:    eth_insert_dst_data = {carry_reg, src_eth_insert_data[MAC_INTERFACE_W-1:ETH_HDR_W]};
            SEL_CARRY_FLUSH: eth_insert_dst_data = {carry_reg, {BODY_W{1'b0}}};
            default:         eth_insert_dst_data = '0;
        endcase
    end

endmodule
